// File: rtl/flag_update_unit.sv
// NZCV flag owner for the dual-issue execute stage: gated partial writes, lane forwarding, one branch checkpoint.
// Optional flag-write statistics counter enabled by defining FLAG_STATS_EN.

module flag_update_lane (
  input  logic [3:0] i_FlagsIn,
  input  logic       i_Wr,
  input  logic [1:0] i_En,
  input  logic [3:0] i_ALU,
  output logic [3:0] o_FlagsOut
);
  logic [1:0] w_en;

  assign w_en = i_Wr ? i_En : 2'b00;

  // [1] covers N,Z and [0] covers C,V
  assign o_FlagsOut = {w_en[1] ? i_ALU[3:2] : i_FlagsIn[3:2],
                       w_en[0] ? i_ALU[1:0] : i_FlagsIn[1:0]};
endmodule

module flag_update_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_StallE,
  input  logic             i_FlushE,
  input  logic             i_Valid0E,
  input  logic             i_CondEx0E,
  input  logic [1:0]       i_FlagWrite0E,
  input  logic [3:0]       i_ALUFlags0E,
  input  logic             i_Valid1E,
  input  logic             i_CondEx1E,
  input  logic [1:0]       i_FlagWrite1E,
  input  logic [3:0]       i_ALUFlags1E,
  input  logic             i_Checkpoint,
  input  logic             i_Restore,
  output logic [3:0]       o_Flags0E,
  output logic [3:0]       o_Flags1E,
  output logic [3:0]       o_FlagsReg,
  output logic             o_CkptValid,
  output logic             o_RestoreErr
`ifdef FLAG_STATS_EN
  ,
  output logic [CNT_W-1:0] o_FlagWrCnt
`endif
);
  localparam int NUM_LANES = 2;

  logic [3:0]                 r_flags;
  logic [3:0]                 r_ckpt;
  logic                       r_ckpt_vld;
  logic                       r_restore_err;

  logic [NUM_LANES-1:0]       w_wr;
  logic [NUM_LANES-1:0][1:0]  w_en;
  logic [NUM_LANES-1:0][3:0]  w_alu;
  logic [NUM_LANES:0][3:0]    w_chain;

  // Lane 0 is older: it sits first in the chain so lane 1 overrides overlapping fields.
  assign w_wr[0]  = i_Valid0E & i_CondEx0E & ~i_FlushE & ~i_StallE;
  assign w_wr[1]  = i_Valid1E & i_CondEx1E & ~i_FlushE & ~i_StallE;
  assign w_en     = {i_FlagWrite1E, i_FlagWrite0E};
  assign w_alu    = {i_ALUFlags1E, i_ALUFlags0E};
  assign w_chain[0] = r_flags;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    flag_update_lane u_lane (
      .i_FlagsIn  (w_chain[g]),
      .i_Wr       (w_wr[g]),
      .i_En       (w_en[g]),
      .i_ALU      (w_alu[g]),
      .o_FlagsOut (w_chain[g+1])
    );
  end

  // Lane 1 sees lane 0's update only; i_CondEx1E never reaches an output combinationally.
  assign o_Flags0E    = r_flags;
  assign o_Flags1E    = w_chain[1];
  assign o_FlagsReg   = r_flags;
  assign o_CkptValid  = r_ckpt_vld;
  assign o_RestoreErr = r_restore_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flags       <= RESET_FLAGS;
      r_ckpt        <= RESET_FLAGS;
      r_ckpt_vld    <= 1'b0;
      r_restore_err <= 1'b0;
    end else if (i_Restore) begin
      if (r_ckpt_vld) begin
        r_flags    <= r_ckpt;
        r_ckpt_vld <= 1'b0;
      end else begin
        r_restore_err <= 1'b1;
      end
    end else if (!i_StallE) begin
      r_flags <= w_chain[NUM_LANES];
      if (i_Checkpoint) begin
        r_ckpt     <= w_chain[NUM_LANES];
        r_ckpt_vld <= 1'b1;
      end
    end
  end

`ifdef FLAG_STATS_EN
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W:0]   w_cnt_sum;
  logic [1:0]       w_inc;

  assign w_inc     = {1'b0, |i_FlagWrite0E & w_wr[0]} + {1'b0, |i_FlagWrite1E & w_wr[1]};
  assign w_cnt_sum = {1'b0, r_wr_cnt} + {{(CNT_W-1){1'b0}}, w_inc};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_cnt <= '0;
    end else if (!i_Restore && !i_StallE) begin
      r_wr_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign o_FlagWrCnt = r_wr_cnt;
`endif
endmodule

// File: tb/tb_flag_update_unit.sv
// Directed + random bench for flag_update_unit against a field-level flag model.
// Define FLAG_STATS_EN to also check the saturating write counter (built with CNT_W=2).
module tb_flag_update_unit;
`ifdef FLAG_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst, stall, flush, v0, c0, v1, c1, ckpt, rest;
  logic [1:0] fw0, fw1;
  logic [3:0] a0, a1;
  logic [3:0] f0e, f1e, freg;
  logic ckv, rerr;
`ifdef FLAG_STATS_EN
  logic [CW-1:0] cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [3:0] m_flags, m_ckpt;
  logic m_cv, m_err;
  int m_cnt;

  always #5 clk = ~clk;

  flag_update_unit #(.RESET_FLAGS(4'b0000), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_StallE(stall), .i_FlushE(flush),
    .i_Valid0E(v0), .i_CondEx0E(c0), .i_FlagWrite0E(fw0), .i_ALUFlags0E(a0),
    .i_Valid1E(v1), .i_CondEx1E(c1), .i_FlagWrite1E(fw1), .i_ALUFlags1E(a1),
    .i_Checkpoint(ckpt), .i_Restore(rest),
    .o_Flags0E(f0e), .o_Flags1E(f1e), .o_FlagsReg(freg),
    .o_CkptValid(ckv), .o_RestoreErr(rerr)
`ifdef FLAG_STATS_EN
    , .o_FlagWrCnt(cnt)
`endif
  );

  function automatic logic [3:0] upd(input logic [3:0] f, input logic [1:0] en, input logic [3:0] alu);
    logic [3:0] r;
    r = f;
    if (en[1]) begin r[3] = alu[3]; r[2] = alu[2]; end
    if (en[0]) begin r[1] = alu[1]; r[0] = alu[0]; end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; ckpt = 0; rest = 0;
    v0 = 0; c0 = 0; fw0 = 0; a0 = 0; v1 = 0; c1 = 0; fw1 = 0; a1 = 0;
  endtask

  // Called just after a negedge with inputs set: checks outputs, then steps the model across one posedge.
  task automatic cyc();
    logic w0, w1;
    logic [3:0] mf0, mf1;
    int inc;
    #1;
    w0 = v0 && c0 && !flush && !stall;
    w1 = v1 && c1 && !flush && !stall;
    mf0 = upd(m_flags, w0 ? fw0 : 2'b00, a0);
    mf1 = upd(mf0, w1 ? fw1 : 2'b00, a1);
    chk("flags0E", {12'h0, f0e}, {12'h0, m_flags});
    chk("flags1E", {12'h0, f1e}, {12'h0, mf0});
    chk("flagsReg", {12'h0, freg}, {12'h0, m_flags});
    chk("ckptValid", {15'h0, ckv}, {15'h0, m_cv});
    chk("restoreErr", {15'h0, rerr}, {15'h0, m_err});
`ifdef FLAG_STATS_EN
    chk("wrCnt", 16'(cnt), 16'(m_cnt));
`endif
    inc = ((fw0 != 0) && w0 ? 1 : 0) + ((fw1 != 0) && w1 ? 1 : 0);
    @(posedge clk);
    if (rst) begin
      m_flags = 4'b0000; m_ckpt = 4'b0000; m_cv = 0; m_err = 0; m_cnt = 0;
    end else if (rest) begin
      if (m_cv) begin m_flags = m_ckpt; m_cv = 0; end
      else m_err = 1;
    end else if (!stall) begin
      m_flags = mf1;
      if (ckpt) begin m_ckpt = mf1; m_cv = 1; end
      m_cnt = m_cnt + inc;
      if (m_cnt > (1 << CW) - 1) m_cnt = (1 << CW) - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); idle();
  endtask

  initial begin
    idle(); rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    m_flags = 0; m_ckpt = 0; m_cv = 0; m_err = 0; m_cnt = 0;

    // reset state
    cyc();
    chk("rst_reg", {12'h0, freg}, 16'h0);
    chk("rst_ckv", {15'h0, ckv}, 16'h0);

    // lane 0 full write visible to lane 1 same cycle, registered next
    v0 = 1; c0 = 1; fw0 = 2'b11; a0 = 4'b0100;
    #1 chk("tp1_f1e", {12'h0, f1e}, 16'h4);
    cyc(); idle();
    chk("tp1_reg", {12'h0, freg}, 16'h4);

    // partial writes merge, then lane 1 wins on overlap
    do_reset();
    v0 = 1; c0 = 1; fw0 = 2'b10; a0 = 4'b1111;
    v1 = 1; c1 = 1; fw1 = 2'b01; a1 = 4'b0011;
    #1 chk("tp2_f1e", {12'h0, f1e}, 16'hC);
    cyc(); idle();
    chk("tp2_reg", {12'h0, freg}, 16'hF);
    v0 = 1; c0 = 1; fw0 = 2'b11; a0 = 4'b1111;
    v1 = 1; c1 = 1; fw1 = 2'b11; a1 = 4'b0000;
    cyc(); idle();
    chk("tp2_win", {12'h0, freg}, 16'h0);

    // stall and flush both block writes
    v0 = 1; c0 = 1; fw0 = 2'b11; a0 = 4'b1010;
    cyc(); idle();
    for (int k = 0; k < 2; k++) begin
      v0 = 1; c0 = 1; fw0 = 2'b11; a0 = 4'b0101;
      v1 = 1; c1 = 1; fw1 = 2'b11; a1 = 4'b0110;
      if (k == 0) stall = 1; else flush = 1;
      #1 chk("tp3_f1e", {12'h0, f1e}, 16'hA);
      cyc(); idle();
      chk("tp3_reg", {12'h0, freg}, 16'hA);
    end

    // checkpoint, overwrite, restore
    do_reset();
    v0 = 1; c0 = 1; fw0 = 2'b11; a0 = 4'b0110; ckpt = 1;
    cyc(); idle();
    chk("tp4_ckv", {15'h0, ckv}, 16'h1);
    v1 = 1; c1 = 1; fw1 = 2'b11; a1 = 4'b1001;
    cyc(); idle();
    chk("tp4_reg", {12'h0, freg}, 16'h9);
    rest = 1; v0 = 1; c0 = 1; fw0 = 2'b11; a0 = 4'b1111; ckpt = 1;
    cyc(); idle();
    chk("tp4_rest", {12'h0, freg}, 16'h6);
    chk("tp4_ckv0", {15'h0, ckv}, 16'h0);

    // restore with no checkpoint is a sticky error
    rest = 1;
    cyc(); idle();
    chk("tp5_reg", {12'h0, freg}, 16'h6);
    chk("tp5_err", {15'h0, rerr}, 16'h1);
    repeat (3) cyc();
    chk("tp5_hold", {15'h0, rerr}, 16'h1);
    do_reset();
    chk("tp5_clr", {15'h0, rerr}, 16'h0);

`ifdef FLAG_STATS_EN
    for (int k = 0; k < 3; k++) begin
      v0 = 1; c0 = 1; fw0 = 2'b11; a0 = 4'(k);
      v1 = 1; c1 = 1; fw1 = 2'b01; a1 = 4'(k + 5);
      cyc(); idle();
      chk("tp6_cnt", 16'(cnt), (k == 0) ? 16'd2 : 16'd3);
    end
    do_reset();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      ckpt  = ($urandom_range(0, 6) == 0);
      rest  = ($urandom_range(0, 9) == 0);
      v0 = 1'($urandom); c0 = 1'($urandom); fw0 = 2'($urandom); a0 = 4'($urandom);
      v1 = 1'($urandom); c1 = 1'($urandom); fw1 = 2'($urandom); a1 = 4'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
